// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_e    : controller states (IDLE, RUN, DONE)
//   DIV_WIDTH      : default operand/result width
//   div_cnt_w()    : iteration-counter width for a given operand width
//   DIV_CNT_W      : counter width for the default operand width
//   DIV0_QUOT_FILL : bit replicated across the quotient on divide by zero
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 8;

  // The counter must be able to hold values 0..width.
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

  localparam logic DIV0_QUOT_FILL = 1'b1;

endpackage

// File: rtl/div_trial_subtractor.sv
// Trial subtraction for one restoring-division step.
//   s       in  WIDTH+1  shifted partial remainder {P[WIDTH-1:0], Q msb}
//   divisor in  WIDTH    divisor magnitude
//   t       out WIDTH    low bits of s - divisor (new P when non_neg)
//   non_neg out 1        high when s >= divisor (new quotient bit)
module div_trial_subtractor
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   s,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] t,
  output logic             non_neg
);

  logic [WIDTH:0] diff;

  assign diff    = s - {1'b0, divisor};
  assign t       = diff[WIDTH-1:0];
  assign non_neg = ~diff[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider behind a start/done handshake.
// One trial subtraction per RUN cycle, WIDTH cycles per division.
//   clk, reset         : clock, synchronous active-high reset
//   start              : request, honoured only in IDLE or DONE
//   dividend, divisor  : operands, captured when start is accepted
//   busy               : high while iterating
//   done               : one-cycle pulse when results are loaded
//   quotient/remainder : results, held until the next accepted start
//   div_by_zero        : set with results when divisor was zero
// Optional build macro SEQ_DIV_SIGNED_EN adds signed_op (two's complement
// operands, truncating division) and overflow (most-negative / -1).
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             signed_op,
  output logic             overflow,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       state_r, state_d;
  logic [WIDTH-1:0] part_rem_r, shift_q_r, divisor_r;
  logic [CNT_W-1:0] iter_cnt_r;
  logic             accept, in_run, divisor_zero, last_iter;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] trial_t;
  logic             trial_ok;
  logic [WIDTH-1:0] next_rem, next_q;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, quot_res, rem_res;

  assign in_run       = (state_r == RUN);
  assign accept       = start && ((state_r == IDLE) || (state_r == DONE));
  assign divisor_zero = (divisor == '0);
  assign last_iter    = (iter_cnt_r == LAST_ITER);

  assign trial_s = {part_rem_r, shift_q_r[WIDTH-1]};

  div_trial_subtractor #(.WIDTH(WIDTH)) u_trial (
    .s       (trial_s),
    .divisor (divisor_r),
    .t       (trial_t),
    .non_neg (trial_ok)
  );

  // Restore on a negative trial by keeping the shifted value. The partial
  // remainder stays below the divisor, so WIDTH bits always hold it.
  assign next_rem = trial_ok ? trial_t : trial_s[WIDTH-1:0];
  assign next_q   = {shift_q_r[WIDTH-2:0], trial_ok};

`ifdef SEQ_DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic neg_quot_r, neg_rem_r, ovf_r;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // The core always divides magnitudes; signs are stripped at capture and
  // reapplied when results are loaded, so latency is unchanged.
  assign dvd_mag  = apply_sign(dividend, signed_op && dividend[WIDTH-1]);
  assign dvs_mag  = apply_sign(divisor,  signed_op && divisor[WIDTH-1]);
  assign quot_res = apply_sign(next_q,   neg_quot_r);
  assign rem_res  = apply_sign(next_rem, neg_rem_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_quot_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      ovf_r      <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      neg_quot_r <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem_r  <= signed_op && dividend[WIDTH-1];
      ovf_r      <= signed_op && (dividend == MOST_NEG) && (divisor == '1);
      if (divisor_zero) overflow <= 1'b0;
    end else if (in_run && last_iter) begin
      overflow <= ovf_r;
    end
  end
`else
  assign dvd_mag  = dividend;
  assign dvs_mag  = divisor;
  assign quot_res = next_q;
  assign rem_res  = next_rem;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_d;
  end

  always_comb begin
    state_d = state_r;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_d = divisor_zero ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = divisor_zero ? DONE : RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Results only change on entry to DONE; the previous answer stays
  // readable while the next division iterates.
  always_ff @(posedge clk) begin
    if (reset) begin
      part_rem_r  <= '0;
      shift_q_r   <= '0;
      divisor_r   <= '0;
      iter_cnt_r  <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      part_rem_r <= '0;
      shift_q_r  <= dvd_mag;
      divisor_r  <= dvs_mag;
      iter_cnt_r <= '0;
      if (divisor_zero) begin
        quotient    <= {WIDTH{DIV0_QUOT_FILL}};
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (in_run) begin
      part_rem_r <= next_rem;
      shift_q_r  <= next_q;
      iter_cnt_r <= iter_cnt_r + CNT_W'(1);
      if (last_iter) begin
        quotient    <= quot_res;
        remainder   <= rem_res;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH = 8).
// Directed handshake scenarios followed by random operands, each compared
// against a plain-arithmetic reference model.
module tb_seq_restoring_divider;
  import div_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
`ifdef SEQ_DIV_SIGNED_EN
  logic         signed_op, overflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SEQ_DIV_SIGNED_EN
    .signed_op   (signed_op),
    .overflow    (overflow),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero when signed.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
    int sa, sb, sq, sr;
    dz = (b == 0);
    if (dz) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[W-1:0];
      r  = sr[W-1:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one division from IDLE or DONE and follow it to its done pulse.
  // inject_at > 0 pulses a competing start (10/3) at that RUN cycle.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit sgn, input int inject_at);
    logic [W-1:0] eq, er, held_q;
    bit           edz, held_ok;
    int           lat, busy_cyc;
    model(a, b, sgn, eq, er, edz);
    held_q   = quotient;
    dividend = a;
    divisor  = b;
`ifdef SEQ_DIV_SIGNED_EN
    signed_op = sgn;
`endif
    start = 1'b1;
    step();
    start    = 1'b0;
    lat      = 1;
    busy_cyc = 0;
    held_ok  = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      if (quotient !== held_q) held_ok = 1'b0;
      if (lat == inject_at) begin
        dividend = 8'd10;
        divisor  = 8'd3;
        start    = 1'b1;
      end
      step();
      start = 1'b0;
      lat++;
    end
    check({tag, " latency"}, lat, edz ? 1 : W + 1);
    check({tag, " busy cycles"}, busy_cyc, edz ? 0 : W);
    check({tag, " results held during run"}, held_ok, 1);
    check({tag, " done"}, done, 1);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, edz);
`ifdef SEQ_DIV_SIGNED_EN
    check({tag, " overflow"}, overflow, (!edz && sgn && a == 8'h80 && b == 8'hFF));
`endif
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int dones = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done) dones++;
    end
    check({tag, " no done pulse"}, dones, 0);
    check({tag, " idle"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef SEQ_DIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    step();
    step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", div_by_zero, 0);
    reset = 1'b0;
    step();

    run_div("200/7", 8'd200, 8'd7, 1'b0, 0);
    step();
    check("200/7 done one-shot", done, 0);
    check("200/7 back to idle", busy, 0);

    run_div("255/1", 8'd255, 8'd1, 1'b0, 0);
    run_div("5/9 back-to-back", 8'd5, 8'd9, 1'b0, 0);
    step();
    check("5/9 done one-shot", done, 0);

    run_div("42/0", 8'd42, 8'd0, 1'b0, 0);
    step();

    run_div("100/10 with start in run", 8'd100, 8'd10, 1'b0, 3);
    expect_quiet("after 100/10", 12);

    dividend = 8'd77;
    divisor  = 8'd5;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("mid-run busy before reset", busy, 1);
    reset = 1'b1;
    step();
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort div_by_zero", div_by_zero, 0);
    reset = 1'b0;
    expect_quiet("after abort", 12);
    run_div("77/5", 8'd77, 8'd5, 1'b0, 0);

    run_div("0/5", 8'd0, 8'd5, 1'b0, 0);
    run_div("255/255", 8'd255, 8'd255, 1'b0, 0);
    run_div("254/255", 8'd254, 8'd255, 1'b0, 0);
    run_div("128/2", 8'd128, 8'd2, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : W'($urandom);
      run_div("random unsigned", ra, rb, 1'b0, 0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end

`ifdef SEQ_DIV_SIGNED_EN
    run_div("-100/7", 8'h9C, 8'd7, 1'b1, 0);
    run_div("-128/-1", 8'h80, 8'hFF, 1'b1, 0);
    run_div("100/-7", 8'd100, 8'hF9, 1'b1, 0);
    run_div("-5/0 signed", 8'hFB, 8'd0, 1'b1, 0);
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : W'($urandom);
      run_div("random signed", ra, rb, 1'b1, 0);
    end
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
